serial_compare_ctrl: RTL and testbench

- Multi-cycle magnitude comparator controller for WIDTH-bit unsigned operands.
- Reuses one 2-bit comparator datapath (comparator_2bit) and sequences it over the operand in 2-bit digits, MSB digit first.
- Stops on the first unequal digit when early exit is enabled.
- Used where a wide combinational compare is too costly. Start/busy/done handshake toward the requester.

---
 rtl/serial_compare_ctrl_pkg.sv | 16 +
 rtl/serial_compare_ctrl_cmp2.sv | 15 +
 rtl/serial_compare_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_compare_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// Operands are walked two bits at a time, MSB digit first.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIGIT_W = 2;

    function automatic int ndig(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/serial_compare_ctrl_cmp2.sv
// Combinational 2-bit unsigned magnitude comparator; the per-digit datapath
// that the serial controller reuses on every step.
module comparator_2bit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_gt,
    output logic       o_lt,
    output logic       o_eq
);

    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Multi-cycle magnitude comparator: captures A/B on start, then scans them
// one 2-bit digit per clock (MSB first) through a single comparator_2bit.
module serial_compare_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agb,
    output logic             alb,
    output logic             aeb
);

    localparam int NDIG  = ndig(WIDTH);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_compare_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_sticky_gt;
    logic                 r_sticky_lt;

    logic [DIGIT_W-1:0]   w_a_digs [NDIG];
    logic [DIGIT_W-1:0]   w_b_digs [NDIG];
    logic [DIGIT_W-1:0]   w_a_dig;
    logic [DIGIT_W-1:0]   w_b_dig;
    logic                 w_gt;
    logic                 w_lt;
    logic                 w_eq;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digits
            assign w_a_digs[gi] = r_a[DIGIT_W*gi +: DIGIT_W];
            assign w_b_digs[gi] = r_b[DIGIT_W*gi +: DIGIT_W];
        end
    endgenerate

    assign w_a_dig = w_a_digs[r_idx];
    assign w_b_dig = w_b_digs[r_idx];

    comparator_2bit u_cmp (
        .i_a  (w_a_dig),
        .i_b  (w_b_dig),
        .o_gt (w_gt),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_sticky_gt <= 1'b0;
            r_sticky_lt <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            agb         <= 1'b0;
            alb         <= 1'b0;
            aeb         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_idx       <= IDX_W'(NDIG - 1);
                        r_sticky_gt <= 1'b0;
                        r_sticky_lt <= 1'b0;
                        r_state     <= RUN;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (!w_eq && EARLY_EXIT) begin
                        agb     <= w_gt;
                        alb     <= w_lt;
                        aeb     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        // First unequal digit wins; less significant digits never override it.
                        if (!w_eq && !r_sticky_gt && !r_sticky_lt) begin
                            r_sticky_gt <= w_gt;
                            r_sticky_lt <= w_lt;
                        end
                        if (r_idx == '0) begin
                            agb     <= r_sticky_gt | (!r_sticky_lt & w_gt);
                            alb     <= r_sticky_lt | (!r_sticky_gt & w_lt);
                            aeb     <= !r_sticky_gt & !r_sticky_lt & w_eq;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench: one early-exit and one fixed-latency instance driven with
// the same operands, checked against hand-computed results and latencies.
module tb_serial_compare_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic busy0, done0, agb0, alb0, aeb0;
    logic busy1, done1, agb1, alb1, aeb1;

    int n_checks = 0;
    int n_fail   = 0;

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
        .busy(busy0), .done(done0), .agb(agb0), .alb(alb0), .aeb(aeb0)
    );

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_fix (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
        .busy(busy1), .done(done1), .agb(agb1), .alb(alb1), .aeb(aeb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       gt;
        logic       lt;
        logic       eq;
        int         lat_ee;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Starts a compare on both instances; when disturb is set, start is
    // re-asserted and the operands are scrambled during the first RUN cycles.
    task automatic do_compare(input vec_t v, input bit disturb);
        int  cyc;
        bit  seen0;
        bit  seen1;
        @(negedge clk);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_ee_after_accept", int'(busy0), 1);
        chk("busy_fix_after_accept", int'(busy1), 1);
        cyc   = 0;
        seen0 = 1'b0;
        seen1 = 1'b0;
        while (!(seen0 && seen1) && cyc < 12) begin
            if (disturb && cyc < 2) begin
                start = 1'b1;
                a_in  = ~v.a;
                b_in  = ~v.b;
            end else if (disturb) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done0 && !seen0) begin
                seen0 = 1'b1;
                chk("lat_ee", cyc, v.lat_ee);
                chk("agb_ee", int'(agb0), int'(v.gt));
                chk("alb_ee", int'(alb0), int'(v.lt));
                chk("aeb_ee", int'(aeb0), int'(v.eq));
                chk("busy_ee_at_done", int'(busy0), 0);
            end
            if (done1 && !seen1) begin
                seen1 = 1'b1;
                chk("lat_fix", cyc, 4);
                chk("agb_fix", int'(agb1), int'(v.gt));
                chk("alb_fix", int'(alb1), int'(v.lt));
                chk("aeb_fix", int'(aeb1), int'(v.eq));
            end
        end
        start = 1'b0;
        if (!seen0) chk("timeout_ee", 0, 1);
        if (!seen1) chk("timeout_fix", 0, 1);
        $display("cmp a=%02h b=%02h -> ee gt/lt/eq=%0d%0d%0d fix gt/lt/eq=%0d%0d%0d",
                 v.a, v.b, agb0, alb0, aeb0, agb1, alb1, aeb1);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done0 || done1) pulses++;
        end
        chk(name, pulses, 0);
    endtask

    vec_t vecs [10];
    vec_t v;

    initial begin
        vecs[0] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h3C, 8'h3D, 1'b0, 1'b1, 1'b0, 4};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 4};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 2};
        vecs[5] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
        vecs[6] = '{8'hC8, 8'hC4, 1'b1, 1'b0, 1'b0, 3};
        vecs[7] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 4};
        vecs[8] = '{8'hFE, 8'hFF, 1'b0, 1'b1, 1'b0, 4};
        vecs[9] = '{8'h69, 8'h96, 1'b0, 1'b1, 1'b0, 1};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_ee", int'(busy0), 0);
        chk("rst_done_ee", int'(done0), 0);
        chk("rst_res_ee", int'({agb0, alb0, aeb0}), 0);
        chk("rst_busy_fix", int'(busy1), 0);
        chk("rst_done_fix", int'(done1), 0);
        chk("rst_res_fix", int'({agb1, alb1, aeb1}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Consecutive vectors start in the done cycle of the previous compare.
        for (int i = 0; i < 10; i++) begin
            do_compare(vecs[i], 1'b0);
        end
        check_quiet("no_extra_done", 3);

        // start and operand changes while busy must not disturb the compare.
        v = '{8'h3C, 8'h3D, 1'b0, 1'b1, 1'b0, 4};
        do_compare(v, 1'b1);
        check_quiet("no_done_after_ignored_start", 4);
        chk("busy_ee_idle_after_ignored", int'(busy0), 0);

        // Reset in the middle of a compare discards it.
        @(negedge clk);
        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_busy_ee", int'(busy0), 0);
        chk("midrun_rst_busy_fix", int'(busy1), 0);
        chk("midrun_rst_done", int'(done0 | done1), 0);
        chk("midrun_rst_res_ee", int'({agb0, alb0, aeb0}), 0);
        chk("midrun_rst_res_fix", int'({agb1, alb1, aeb1}), 0);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-run reset applied, outputs busy=%0d/%0d res=%0d%0d%0d", busy0, busy1, agb0, alb0, aeb0);
        check_quiet("no_done_after_rst", 6);
        v = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 4};
        do_compare(v, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
